// File: rtl/jpeg_pixel_writer.sv
// RGB888 pixel stream to RGB565 framebuffer writer for the JPEG decoder output.
// Two-stage pipeline: S1 converts colour and forms y*width, S2 forms the address and range check.
module jpeg_pixel_writer #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] frame_base_i,
   input  logic              inport_valid_i,
   output logic              inport_accept_o,
   input  logic [15:0]       inport_width_i,
   input  logic [15:0]       inport_height_i,
   input  logic [15:0]       inport_pixel_x_i,
   input  logic [15:0]       inport_pixel_y_i,
   input  logic [7:0]        inport_pixel_r_i,
   input  logic [7:0]        inport_pixel_g_i,
   input  logic [7:0]        inport_pixel_b_i,
   output logic              wr_valid_o,
   input  logic              wr_ready_i,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [15:0]       wr_data_o,
   output logic              frame_done_o,
   output logic              err_o,
   output logic              idle_o
);

   localparam int unsigned PIX_W  = 16;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 32;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic [0:0]        r_state;
   logic [0:0]        w_next_state;

   logic              r_s1_valid;
   logic [DATA_W-1:0] r_s1_rgb;
   logic [CNT_W-1:0]  r_s1_prod;
   logic [PIX_W-1:0]  r_s1_x;
   logic [PIX_W-1:0]  r_s1_y;
   logic [PIX_W-1:0]  r_s1_w;
   logic [PIX_W-1:0]  r_s1_h;

   logic              r_s2_valid;
   logic [ADDR_W-1:0] r_s2_addr;
   logic [DATA_W-1:0] r_s2_data;
   logic              r_s2_in_range;

   logic [ADDR_W-1:0] r_base_q;
   logic [CNT_W-1:0]  r_total;
   logic [CNT_W-1:0]  r_count;
   logic              r_err;
   logic              r_frame_done;

   logic              w_accept;
   logic              w_s1_advance;
   logic              w_s2_retire;
   logic              w_frame_start;
   logic              w_frame_end;
   logic              w_last;
   logic [DATA_W-1:0] w_rgb565;
   logic [CNT_W-1:0]  w_prod;
   logic [CNT_W-1:0]  w_total;
   logic [CNT_W-1:0]  w_off;
   logic [ADDR_W-1:0] w_addr;
   logic              w_in_range;

   // Handshake: backpressure ripples combinationally from the write sink to the pixel source.
   assign w_s2_retire     = r_s2_valid & (~r_s2_in_range | wr_ready_i);
   assign w_s1_advance    = ~r_s2_valid | w_s2_retire;
   assign inport_accept_o = ~r_s1_valid | w_s1_advance;
   assign w_accept        = inport_valid_i & inport_accept_o;

   // S1 datapath from the raw input pixel.
   assign w_rgb565 = {inport_pixel_r_i[7:3], inport_pixel_g_i[7:2], inport_pixel_b_i[7:3]};
   assign w_prod   = CNT_W'(inport_pixel_y_i) * CNT_W'(inport_width_i);
   assign w_total  = CNT_W'(inport_width_i) * CNT_W'(inport_height_i);

   // S2 datapath from S1 registers; address arithmetic wraps at ADDR_W.
   assign w_off      = r_s1_prod + CNT_W'(r_s1_x);
   assign w_addr     = r_base_q + ADDR_W'({w_off, 1'b0});
   assign w_in_range = (r_s1_x < r_s1_w) && (r_s1_y < r_s1_h);

   assign w_last = ({1'b0, r_count} + (CNT_W + 1)'(1)) >= {1'b0, r_total};

   // Next-state logic: frame opens on the first accepted pixel, closes on the last retire.
   always_comb begin
      w_next_state  = r_state;
      w_frame_start = 1'b0;
      w_frame_end   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state  = ST_ACTIVE;
               w_frame_start = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (w_s2_retire && w_last) begin
               w_next_state = ST_IDLE;
               w_frame_end  = 1'b1;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Pipeline registers; a held S2 also stalls S1.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_s1_valid    <= 1'b0;
         r_s1_rgb      <= '0;
         r_s1_prod     <= '0;
         r_s1_x        <= '0;
         r_s1_y        <= '0;
         r_s1_w        <= '0;
         r_s1_h        <= '0;
         r_s2_valid    <= 1'b0;
         r_s2_addr     <= '0;
         r_s2_data     <= '0;
         r_s2_in_range <= 1'b0;
      end else begin
         if (inport_accept_o) begin
            r_s1_valid <= inport_valid_i;
            if (inport_valid_i) begin
               r_s1_rgb  <= w_rgb565;
               r_s1_prod <= w_prod;
               r_s1_x    <= inport_pixel_x_i;
               r_s1_y    <= inport_pixel_y_i;
               r_s1_w    <= inport_width_i;
               r_s1_h    <= inport_height_i;
            end
         end
         if (w_s1_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_addr     <= w_addr;
               r_s2_data     <= r_s1_rgb;
               r_s2_in_range <= w_in_range;
            end
         end
      end
   end

   // Per-frame bookkeeping: base and pixel total come from the first pixel only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_base_q     <= '0;
         r_total      <= '0;
         r_count      <= '0;
         r_err        <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_frame_end;
         if (w_frame_start) begin
            r_base_q <= frame_base_i;
            r_total  <= w_total;
            r_count  <= '0;
         end else if (w_frame_end) begin
            r_count  <= '0;
         end else if ((r_state == ST_ACTIVE) && w_s2_retire) begin
            r_count  <= r_count + CNT_W'(1);
         end
         // A dropped pixel outranks the frame-start clear on the same edge.
         if (w_s2_retire && !r_s2_in_range) begin
            r_err <= 1'b1;
         end else if (w_frame_start) begin
            r_err <= 1'b0;
         end
      end
   end

   assign wr_valid_o   = r_s2_valid & r_s2_in_range;
   assign wr_addr_o    = r_s2_addr;
   assign wr_data_o    = r_s2_data;
   assign frame_done_o = r_frame_done;
   assign err_o        = r_err;
   assign idle_o       = (r_state == ST_IDLE) & ~r_s1_valid & ~r_s2_valid;

endmodule
